psum_ofifo: RTL and testbench
=============================

Name: psum_ofifo

Overview:
- Output collection stage directly downstream of the PE row/array. It consumes the per-column partial sums (out_s) and their per-column valid strobes.
- Columns finish at skewed cycles, so each column's psum is buffered in its own FIFO.
- A row vector is released only when every column has data, which re-aligns the skewed outputs into whole rows for SFU/memory write-back.

Parameters:
col, 8, number of columns (one FIFO per column)
psum_bw, 16, width of one partial sum
depth_bits, 4, log2 of per-column FIFO depth (depth = 2**depth_bits = 16)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
wr  input  col  per-column write enable; bit c is driven by PE column c's valid
in  input  psum_bw*col  per-column psum; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
rd  input  1  pop one full row (all columns simultaneously)
out  output  psum_bw*col  registered row output, same column packing as in
out_valid  output  1  high for exactly one cycle when out holds a newly popped row
o_valid  output  1  every column FIFO non-empty (row available)
o_full  output  1  any column FIFO full
o_ready  output  1  equals not o_full
overflow  output  1  sticky flag: a write was dropped

Behaviour:
- Reset (reset=0, asynchronous): all read/write pointers and counts go to 0. out=0, out_valid=0, overflow=0. Resulting outputs: o_valid=0, o_full=0, o_ready=1. Reset mid-operation discards all buffered data; FIFO storage contents need not be cleared.
- Per-column state: write pointer, read pointer (depth_bits wide, wrap modulo depth), and count (depth_bits+1 wide, 0..depth).
- Write, column c: on a clock edge with wr[c]=1, the column-c slice of in is stored at wptr[c], and wptr[c] and count[c] increment. Columns write independently and may write in any combination, including different cycles per column.
- Pop: accepted (pop=1) on a clock edge with rd=1 and o_valid=1. Then:
  - every column's rptr increments;
  - every column's count decrements;
  - out is loaded with the head entry of every column;
  - out_valid=1 in the following cycle.
  Latency: rd edge to out/out_valid is 1 cycle.
- rd=1 with o_valid=0: ignored. No pointer change, out holds, out_valid=0. Not an error.
- out_valid=0 in every cycle not following an accepted pop. out holds its last value between pops.
- Write to a full column, no pop in the same cycle: the write is dropped, the column is unchanged, and overflow is set to 1. overflow stays 1 until reset.
- Write to a full column while a pop is accepted in the same cycle: the write is accepted. The count stays at depth and both pointers advance.
- Simultaneous write and pop on a non-full column: count unchanged, both pointers advance.
- A write to an empty column never bypasses to out in the same cycle. Data written at edge N is poppable at the earliest at edge N+1.
- o_valid, o_full and o_ready are combinational from the counts only. They do not depend on wr or rd in the current cycle.
- Pointer wrap: after depth writes, wptr returns to 0. Data order within each column is strictly FIFO across the wrap.
- No arithmetic on data: psums pass through bit-exact with no sign extension or truncation.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release. Required: o_valid=0, o_ready=1, o_full=0, overflow=0, out=0, out_valid=0.
- Skewed fill: col=8; column c writes value 16'h0100+c at cycle c (one column per cycle, cycles 0..7).
  - Required: o_valid=0 through cycle 7 and o_valid=1 after the column-7 write edge.
  - rd=1 for one cycle gives out_valid=1 the next cycle, with each column slice = 16'h0100+c.
  - o_valid=0 afterwards.
- Full/overflow: write 16 entries (values 0..15) to all columns, then a 17th write (value 99) with rd=0.
  - Required: o_full=1 and o_ready=0 after the 16th write; overflow=1 after the 17th.
  - 16 pops return 0..15 in order on every column; value 99 never appears.
- Full with simultaneous pop: fill all columns to 16, then assert wr=all and rd=1 in the same cycle with value 77.
  - Required: count stays 16 and overflow stays 0.
  - Subsequent pops return 1..15 then 77.
- Wrap-around: 3 rounds of 10 writes then 10 pops, values incrementing from 0. Required: 30 pops return 0..29 in order (pointers wrap past 16).
- Mid-operation reset and empty read: with 5 rows buffered, pulse reset=0 asynchronously between edges. Required: o_valid=0 immediately. A following rd=1 gives out_valid=0 and out=0.

Source files
------------

// File: rtl/psum_ofifo.sv
`default_nettype none
// ============================================================================
// Module      : psum_ofifo
// Description : Output collection FIFO behind the PE array. Each column owns
//               its own FIFO because columns finish at skewed cycles. A row
//               is popped only when every column holds data, which
//               re-aligns the skewed psums into whole rows.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_ofifo #(
  parameter int COL        = 8,
  parameter int PSUM_BW    = 16,
  parameter int DEPTH_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,      // asynchronous, active low
  input  logic [COL-1:0]         wr,
  input  logic [PSUM_BW*COL-1:0] in,
  input  logic                   rd,
  output logic [PSUM_BW*COL-1:0] out,
  output logic                   out_valid,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);

  localparam int              c_entries = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_depth = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [COL-1:0] w_nonempty;
  logic [COL-1:0] w_full_vec;
  logic [COL-1:0] w_drop_vec;
  logic           w_pop;
  logic           r_out_valid;
  logic           r_overflow;

  // A row pops only when every column has an entry; rd otherwise is ignored.
  assign w_pop    = rd & o_valid;

  // Status flags depend on the stored counts only, never on this cycle's wr/rd.
  assign o_valid  = &w_nonempty;
  assign o_full   = |w_full_vec;
  assign o_ready  = ~o_full;

  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;

  generate
    for (genvar c = 0; c < COL; c++) begin : g_col
      logic [DEPTH_BITS-1:0] r_wptr;
      logic [DEPTH_BITS-1:0] r_rptr;
      logic [DEPTH_BITS:0]   r_count;
      logic [PSUM_BW-1:0]    r_mem [c_entries];
      logic [PSUM_BW-1:0]    r_out;
      logic                  w_full;
      logic                  w_wr_ok;

      assign w_full        = (r_count == c_depth);
      // A full column still accepts a write when the same edge frees a slot.
      assign w_wr_ok       = wr[c] & (~w_full | w_pop);
      assign w_nonempty[c] = (r_count != '0);
      assign w_full_vec[c] = w_full;
      assign w_drop_vec[c] = wr[c] & w_full & ~w_pop;
      assign out[c*PSUM_BW +: PSUM_BW] = r_out;

      // Storage is not reset; pointers/counts alone define what is valid.
      always_ff @(posedge clk) begin
        if (w_wr_ok) begin
          r_mem[r_wptr] <= in[c*PSUM_BW +: PSUM_BW];
        end
      end

      // Pointer, occupancy and head-register bookkeeping for this column.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
          r_out   <= '0;
        end else begin
          if (w_wr_ok) begin
            r_wptr <= r_wptr + DEPTH_BITS'(1);
          end
          if (w_pop) begin
            r_rptr <= r_rptr + DEPTH_BITS'(1);
            r_out  <= r_mem[r_rptr];
          end
          case ({w_wr_ok, w_pop})
            2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
            2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // Row-valid strobe and the sticky dropped-write flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      r_overflow  <= r_overflow | (|w_drop_vec);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_ofifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_ofifo
// Description : Directed self-checking bench for psum_ofifo (8 x 16-bit
//               columns, depth 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_ofifo;

  localparam int COL        = 8;
  localparam int PSUM_BW    = 16;
  localparam int DEPTH_BITS = 4;
  localparam int W          = COL * PSUM_BW;

  logic           clk;
  logic           reset;
  logic [COL-1:0] wr;
  logic [W-1:0]   psum_in;
  logic           rd;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
  logic           overflow;

  int n_checks;
  int n_errors;

  psum_ofifo #(
    .COL        (COL),
    .PSUM_BW    (PSUM_BW),
    .DEPTH_BITS (DEPTH_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .in        (psum_in),
    .rd        (rd),
    .out       (out),
    .out_valid (out_valid),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_ready   (o_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Replicate one psum value into every column slice.
  function automatic logic [W-1:0] rep(input logic [PSUM_BW-1:0] v);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PSUM_BW +: PSUM_BW] = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [W-1:0] exp_row;
    int           n;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    wr       = '0;
    rd       = 1'b0;
    psum_in  = '0;

    // ---------------- reset then idle ----------------
    do_reset();
    check("rst_o_valid",   W'(o_valid),   W'(0));
    check("rst_o_ready",   W'(o_ready),   W'(1));
    check("rst_o_full",    W'(o_full),    W'(0));
    check("rst_overflow",  W'(overflow),  W'(0));
    check("rst_out",       out,           '0);
    check("rst_out_valid", W'(out_valid), W'(0));

    // ---------------- skewed fill ----------------
    exp_row = '0;
    for (int c = 0; c < COL; c++) begin
      check("skew_o_valid_low", W'(o_valid), W'(0));
      wr = COL'(1) << c;
      psum_in = '0;
      psum_in[c*PSUM_BW +: PSUM_BW] = 16'h0100 + PSUM_BW'(c);
      exp_row[c*PSUM_BW +: PSUM_BW] = 16'h0100 + PSUM_BW'(c);
      tick();
    end
    wr = '0;
    check("skew_o_valid_high", W'(o_valid), W'(1));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("skew_out_valid", W'(out_valid), W'(1));
    check("skew_out_row",   out,           exp_row);
    check("skew_empty",     W'(o_valid),   W'(0));
    tick();
    check("skew_out_valid_drop", W'(out_valid), W'(0));
    check("skew_out_hold",       out,           exp_row);

    // ---------------- full / overflow ----------------
    wr = '1;
    for (int v = 0; v < 16; v++) begin
      psum_in = rep(PSUM_BW'(v));
      tick();
    end
    check("full_o_full",   W'(o_full),   W'(1));
    check("full_o_ready",  W'(o_ready),  W'(0));
    check("full_no_ovf",   W'(overflow), W'(0));
    psum_in = rep(16'd99);
    tick();
    wr = '0;
    check("ovf_set",       W'(overflow), W'(1));
    check("ovf_still_full", W'(o_full),  W'(1));
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("ovf_pop_valid", W'(out_valid), W'(1));
      check("ovf_pop_data",  out,           rep(PSUM_BW'(i)));
    end
    rd = 1'b0;
    check("ovf_drained", W'(o_valid), W'(0));
    check("ovf_sticky",  W'(overflow), W'(1));

    // ---------------- full with simultaneous pop ----------------
    do_reset();
    check("fp_ovf_cleared", W'(overflow), W'(0));
    wr = '1;
    for (int v = 0; v < 16; v++) begin
      psum_in = rep(PSUM_BW'(v));
      tick();
    end
    psum_in = rep(16'd77);
    rd = 1'b1;
    tick();
    wr = '0;
    check("fp_still_full",  W'(o_full),    W'(1));
    check("fp_no_ovf",      W'(overflow),  W'(0));
    check("fp_pop_valid",   W'(out_valid), W'(1));
    check("fp_pop_data0",   out,           rep(16'd0));
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("fp_pop_data", out, (i == 16) ? rep(16'd77) : rep(PSUM_BW'(i)));
    end
    rd = 1'b0;
    check("fp_drained",  W'(o_valid),  W'(0));
    check("fp_no_ovf2",  W'(overflow), W'(0));

    // ---------------- wrap-around ----------------
    n = 0;
    for (int r = 0; r < 3; r++) begin
      wr = '1;
      for (int k = 0; k < 10; k++) begin
        psum_in = rep(PSUM_BW'(r*10 + k));
        tick();
      end
      wr = '0;
      rd = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        check("wrap_data", out, rep(PSUM_BW'(n)));
        n++;
      end
      rd = 1'b0;
    end
    check("wrap_drained", W'(o_valid), W'(0));

    // rd on an empty FIFO is ignored: no strobe, out holds.
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("empty_rd_no_valid", W'(out_valid), W'(0));
    check("empty_rd_hold",     out,           rep(16'd29));

    // ---------------- mid-operation reset ----------------
    wr = '1;
    for (int k = 0; k < 5; k++) begin
      psum_in = rep(PSUM_BW'(200 + k));
      tick();
    end
    wr = '0;
    check("mid_o_valid_before", W'(o_valid), W'(1));
    #2;
    reset = 1'b0;
    #1;
    check("mid_o_valid_async", W'(o_valid), W'(0));
    check("mid_out_async",     out,         '0);
    #1;
    reset = 1'b1;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("mid_rd_no_valid", W'(out_valid), W'(0));
    check("mid_rd_out_zero", out,           '0);
    check("mid_still_empty", W'(o_valid),   W'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
